// File: rtl/cc_player1_move_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cc_player1_move_ctrl
// Purpose  : Player-1 one-hot row position with single-step and hold-to-repeat
//            movement from active-low buttons, limited to bits 7..4.
// Option   : CC_PLAYER1_MOVECTRL_WRAP_EN - steps at a limit wrap to the other.
// Revision : 1.0 - initial release
// ============================================================================
module cc_player1_move_ctrl #(
  parameter int                   DATAWIDTH    = 8,
  parameter logic [DATAWIDTH-1:0] HOME_POS     = 8'b00100000,
  parameter logic [DATAWIDTH-1:0] LEFT_LIMIT   = 8'b10000000,
  parameter logic [DATAWIDTH-1:0] RIGHT_LIMIT  = 8'b00010000,
  parameter int                   CNT_WIDTH    = 24,
  parameter int                   REPEAT_DELAY = 12500000,
  parameter int                   REPEAT_RATE  = 5000000
) (
  input  logic                 CC_PLAYER1_MOVECTRL_CLOCK_50,
  input  logic                 CC_PLAYER1_MOVECTRL_RESET_InHigh,
  input  logic                 CC_PLAYER1_MOVECTRL_enable_InHigh,
  input  logic                 CC_PLAYER1_MOVECTRL_left_InLow,
  input  logic                 CC_PLAYER1_MOVECTRL_right_InLow,
  output logic [DATAWIDTH-1:0] CC_PLAYER1_MOVECTRL_position_OutBUS,
  output logic                 CC_PLAYER1_MOVECTRL_izquierda_OutLow,
  output logic                 CC_PLAYER1_MOVECTRL_derecha_OutLow,
  output logic                 CC_PLAYER1_MOVECTRL_moved_OutHigh
);

  localparam logic [1:0] c_ST_IDLE   = 2'd0;
  localparam logic [1:0] c_ST_HOLD   = 2'd1;
  localparam logic [1:0] c_ST_REPEAT = 2'd2;

  localparam logic c_DIR_LEFT  = 1'b1;
  localparam logic c_DIR_RIGHT = 1'b0;

  localparam logic [CNT_WIDTH-1:0] c_DELAY_M1  = CNT_WIDTH'(REPEAT_DELAY - 1);
  localparam logic [CNT_WIDTH-1:0] c_RATE_M1   = CNT_WIDTH'(REPEAT_RATE - 1);
  localparam logic [CNT_WIDTH-1:0] c_TIMER_ONE = CNT_WIDTH'(1);

  logic                 r_left_s1, r_left_s2, r_left_prev;
  logic                 r_right_s1, r_right_s2, r_right_prev;
  logic [1:0]           r_state;
  logic [CNT_WIDTH-1:0] r_timer;
  logic                 r_dir;
  logic [DATAWIDTH-1:0] r_pos;
  logic                 r_moved;

  logic                 w_left_held, w_right_held, w_left_press, w_right_press;
  logic                 w_own_held, w_opp_held;
  logic [1:0]           w_state_next;
  logic [CNT_WIDTH-1:0] w_timer_next;
  logic                 w_dir_next;
  logic                 w_step;
  logic [DATAWIDTH-1:0] w_pos_next;
  logic                 w_moved_next;

  assign w_left_held   = ~r_left_s2;
  assign w_right_held  = ~r_right_s2;
  assign w_left_press  = ~r_left_s2 & r_left_prev;
  assign w_right_press = ~r_right_s2 & r_right_prev;
  assign w_own_held    = (r_dir == c_DIR_LEFT) ? w_left_held  : w_right_held;
  assign w_opp_held    = (r_dir == c_DIR_LEFT) ? w_right_held : w_left_held;

  // Synchronizers run regardless of enable so a held button is never a press.
  always_ff @(posedge CC_PLAYER1_MOVECTRL_CLOCK_50) begin
    if (CC_PLAYER1_MOVECTRL_RESET_InHigh) begin
      r_left_s1    <= 1'b1;
      r_left_s2    <= 1'b1;
      r_left_prev  <= 1'b1;
      r_right_s1   <= 1'b1;
      r_right_s2   <= 1'b1;
      r_right_prev <= 1'b1;
      r_state      <= c_ST_IDLE;
      r_timer      <= '0;
      r_dir        <= c_DIR_RIGHT;
      r_pos        <= HOME_POS;
      r_moved      <= 1'b0;
    end else begin
      r_left_s1    <= CC_PLAYER1_MOVECTRL_left_InLow;
      r_left_s2    <= r_left_s1;
      r_left_prev  <= r_left_s2;
      r_right_s1   <= CC_PLAYER1_MOVECTRL_right_InLow;
      r_right_s2   <= r_right_s1;
      r_right_prev <= r_right_s2;
      r_state      <= w_state_next;
      r_timer      <= w_timer_next;
      r_dir        <= w_dir_next;
      r_pos        <= w_pos_next;
      r_moved      <= w_moved_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_timer_next = r_timer;
    w_dir_next   = r_dir;
    w_step       = 1'b0;
    if (!CC_PLAYER1_MOVECTRL_enable_InHigh) begin
      w_state_next = c_ST_IDLE;
      w_timer_next = '0;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          w_timer_next = '0;
          if (w_left_press && !w_right_held) begin
            w_step       = 1'b1;
            w_dir_next   = c_DIR_LEFT;
            w_state_next = c_ST_HOLD;
          end else if (w_right_press && !w_left_held) begin
            w_step       = 1'b1;
            w_dir_next   = c_DIR_RIGHT;
            w_state_next = c_ST_HOLD;
          end
        end
        c_ST_HOLD, c_ST_REPEAT: begin
          if (!w_own_held || w_opp_held) begin
            w_state_next = c_ST_IDLE;
            w_timer_next = '0;
          end else if (r_timer == ((r_state == c_ST_HOLD) ? c_DELAY_M1 : c_RATE_M1)) begin
            w_step       = 1'b1;
            w_timer_next = '0;
            w_state_next = c_ST_REPEAT;
          end else begin
            w_timer_next = r_timer + c_TIMER_ONE;
          end
        end
        default: begin
          w_state_next = c_ST_IDLE;
          w_timer_next = '0;
        end
      endcase
    end
  end

  // A blocked step at a limit keeps timing but leaves position and moved alone.
  always_comb begin
    w_pos_next = r_pos;
    if (w_step) begin
      if (w_dir_next == c_DIR_LEFT) begin
        if (r_pos != LEFT_LIMIT) w_pos_next = r_pos << 1;
`ifdef CC_PLAYER1_MOVECTRL_WRAP_EN
        else w_pos_next = RIGHT_LIMIT;
`endif
      end else begin
        if (r_pos != RIGHT_LIMIT) w_pos_next = r_pos >> 1;
`ifdef CC_PLAYER1_MOVECTRL_WRAP_EN
        else w_pos_next = LEFT_LIMIT;
`endif
      end
    end
    w_moved_next = (w_pos_next != r_pos);
  end

  assign CC_PLAYER1_MOVECTRL_position_OutBUS   = r_pos;
  assign CC_PLAYER1_MOVECTRL_moved_OutHigh     = r_moved;
  assign CC_PLAYER1_MOVECTRL_izquierda_OutLow  = ~(r_pos == LEFT_LIMIT);
  assign CC_PLAYER1_MOVECTRL_derecha_OutLow    = ~(r_pos == RIGHT_LIMIT);

endmodule
`default_nettype wire

// File: doc/cc_player1_move_ctrl.md
Name: cc_player1_move_ctrl

Overview:
Movement controller for player 1's one-hot position register on the 8-bit matrix row.
- Converts active-low left/right button inputs into single steps plus hold-to-repeat steps.
- Blocks motion at the player-1 side limits (bit 7 = izquierda, bit 4 = derecha).
- Drives the active-low side flags that downstream game logic consumes.
- Sits between the button inputs and the row display/collision logic.

Parameters:
DATAWIDTH, 8, width of position bus
HOME_POS, 8'b00100000, position loaded at reset
LEFT_LIMIT, 8'b10000000, leftmost allowed position (izquierda)
RIGHT_LIMIT, 8'b00010000, rightmost allowed position (derecha)
CNT_WIDTH, 24, width of repeat timer
REPEAT_DELAY, 12500000, held cycles before first auto-repeat (250 ms @ 50 MHz)
REPEAT_RATE, 5000000, cycles between subsequent auto-repeats

Ports:
CC_PLAYER1_MOVECTRL_CLOCK_50  input  1  system clock, all logic on rising edge
CC_PLAYER1_MOVECTRL_RESET_InHigh  input  1  synchronous active-high reset
CC_PLAYER1_MOVECTRL_enable_InHigh  input  1  game running; low freezes movement
CC_PLAYER1_MOVECTRL_left_InLow  input  1  raw left button, active low, asynchronous
CC_PLAYER1_MOVECTRL_right_InLow  input  1  raw right button, active low, asynchronous
CC_PLAYER1_MOVECTRL_position_OutBUS  output  DATAWIDTH  one-hot player position
CC_PLAYER1_MOVECTRL_izquierda_OutLow  output  1  0 when position == LEFT_LIMIT
CC_PLAYER1_MOVECTRL_derecha_OutLow  output  1  0 when position == RIGHT_LIMIT
CC_PLAYER1_MOVECTRL_moved_OutHigh  output  1  one-cycle pulse on each actual position change

Behaviour:
Clock and reset:
- Single clock. Reset is synchronous and active-high.
- Reset values: position = HOME_POS; moved = 0; state IDLE; timer 0; synchronizers and edge registers = 1 (released).
- Flags are decoded from the position register, so after reset both flags = 1.
- Reset asserted mid-repeat aborts immediately. Position returns to HOME_POS on that edge.

Input conditioning:
- Each button passes through a 2-FF synchronizer, then a previous-value register.
- press = sync2 == 0 and prev == 1. held = sync2 == 0.

Direction and limits:
- Left step = position << 1. Right step = position >> 1.
- A step is legal only if position != LEFT_LIMIT (left) or position != RIGHT_LIMIT (right).
- An illegal step leaves position unchanged and gives no moved pulse.

FSM states:
- IDLE: on a left press or right press (exactly one button held), step once, latch the direction, clear the timer, go to HOLD. Both buttons held or both pressed in the same cycle: no step, stay IDLE.
- HOLD: timer increments while the latched button is held. When timer == REPEAT_DELAY-1, step, clear the timer, go to REPEAT. Latched button released, or opposite button held: go to IDLE, timer = 0, no step.
- REPEAT: same as HOLD, but steps every REPEAT_RATE cycles and stays in REPEAT. Release or opposite button held: go to IDLE.

Latency and timing:
- Button falls before edge 1 → sync1 at edge 1, sync2 at edge 2 → position update and moved = 1 at edge 3.
- moved is a registered one-cycle pulse, asserted in the same cycle the new position is visible.
- Holding at a limit keeps cycling HOLD/REPEAT timing but produces no steps and no moved pulses.

Enable:
- enable = 0 forces the FSM to IDLE, clears the timer, and holds position. moved = 0.
- Synchronizers keep running. A button still held when enable rises is not a new press; no step until it is released and pressed again.

Illegal position:
- Position is only ever loaded with HOME_POS or a legal shift. Any non-one-hot value is unreachable.

Optional Feature:
Macro CC_PLAYER1_MOVECTRL_WRAP_EN.
- Defined: a left step at LEFT_LIMIT loads RIGHT_LIMIT, and a right step at RIGHT_LIMIT loads LEFT_LIMIT. Each wrap produces a moved pulse, and repeat continues wrapping.
- Undefined: steps at a limit are blocked as described in Behaviour.

Test Plan:
- Reset with position 8'b10000000 mid-REPEAT → next edge: position 8'b00100000, izquierda = 1, derecha = 1, moved = 0, FSM in IDLE.
- Left button low for 5 cycles (REPEAT_DELAY = 10) → at edge 3, position 8'b00100000 → 8'b01000000 with a single 1-cycle moved pulse; no further steps after release.
- Left held continuously (REPEAT_DELAY = 10, REPEAT_RATE = 4) → steps at edge 3 and edge 13 reaching 8'b10000000, izquierda = 0; later repeat periods give no change and no moved pulse.
- From 8'b00100000, right press → 8'b00010000, derecha = 0. A second right press gives no change, or with WRAP_EN position 8'b10000000, izquierda = 0, moved = 1.
- Both buttons pressed on the same cycle → position unchanged and moved stays 0 for 20 cycles. Then right released while left is held → no step until left is released and pressed again.
- enable = 0 during HOLD with left held → no steps for 30 cycles. enable = 1 with left still held → no step. Release then press left → step at edge 3 after the press.
